// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction memory request/grant/response bus
//
// Signals:
//   imem_req     fetch -> memory  read request
//   imem_addr    fetch -> memory  word-aligned read address
//   imem_gnt     memory -> fetch  request accepted this cycle
//   imem_rvalid  memory -> fetch  imem_rdata valid this cycle
//   imem_rdata   memory -> fetch  returned instruction word
// Modports: master (fetch unit side), slave (memory side).
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - single-outstanding instruction fetch stage with decode hand-off
//
// Parameter:
//   TIMEOUT        cycles spent waiting for a response before a fetch is abandoned (>= 1)
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous active-high reset
//   pc             current program counter
//   flush          taken jump/branch: discards any in-flight or held instruction
//   id_ready       decode accepts the held instruction this cycle
//   imem           instruction memory bus (master side)
//   instr          held instruction word
//   instr_pc       word-aligned address of the held instruction
//   instr_valid    instr/instr_pc are valid
//   pc_advance     one-cycle pulse when decode takes the held instruction
//   fetch_err      sticky flag: a fetch timed out since the last reset
module fetch_unit #(
  parameter int TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  pc,
  input  logic         flush,
  input  logic         id_ready,
  fetch_unit_if.master imem,
  output logic [31:0]  instr,
  output logic [31:0]  instr_pc,
  output logic         instr_valid,
  output logic         pc_advance,
  output logic         fetch_err
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  // Counter value seen during the last permitted idle wait cycle.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_FULL  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [31:0]       req_pc_q;
  logic [31:0]       req_pc_d;
  logic [CNT_W-1:0]  wait_cnt_q;
  logic [CNT_W-1:0]  wait_cnt_d;
  logic [CNT_W-1:0]  wait_inc;
  logic              wait_last;
  logic [31:0]       instr_d;
  logic [31:0]       instr_pc_d;
  logic              instr_valid_d;
  logic              fetch_err_d;
  logic              imem_req_c;
  logic [31:0]       aligned_pc;

  assign aligned_pc     = pc & 32'hFFFF_FFFC;
  assign imem.imem_addr = aligned_pc;
  assign imem.imem_req  = imem_req_c;

  assign wait_inc  = wait_cnt_q + CNT_W'(1);
  assign wait_last = (wait_cnt_q == CNT_LAST);

  always_comb begin
    state_d       = state_q;
    req_pc_d      = req_pc_q;
    wait_cnt_d    = wait_cnt_q;
    instr_d       = instr;
    instr_pc_d    = instr_pc;
    instr_valid_d = instr_valid;
    fetch_err_d   = fetch_err;
    imem_req_c    = 1'b0;
    pc_advance    = 1'b0;

    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
      end

      S_REQ: begin
        imem_req_c = 1'b1;
        if (imem.imem_gnt) begin
          wait_cnt_d = '0;
          // A grant in a flush cycle fetches a stale address; its response
          // must still be absorbed before the next request.
          if (flush) begin
            state_d = S_DRAIN;
          end else begin
            state_d  = S_WAIT;
            req_pc_d = aligned_pc;
          end
        end
      end

      S_WAIT: begin
        if (flush) begin
          if (imem.imem_rvalid) begin
            state_d = S_REQ;
          end else begin
            state_d    = S_DRAIN;
            wait_cnt_d = '0;
          end
        end else if (imem.imem_rvalid) begin
          state_d       = S_FULL;
          instr_d       = imem.imem_rdata;
          instr_pc_d    = req_pc_q;
          instr_valid_d = 1'b1;
        end else if (wait_last) begin
          state_d     = S_REQ;
          wait_cnt_d  = wait_inc;
          fetch_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_inc;
        end
      end

      S_DRAIN: begin
        if (imem.imem_rvalid) begin
          state_d = S_REQ;
        end else if (wait_last) begin
          state_d     = S_REQ;
          wait_cnt_d  = wait_inc;
          fetch_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_inc;
        end
      end

      S_FULL: begin
        // flush has priority: a discarded instruction must never advance the PC.
        if (flush) begin
          instr_valid_d = 1'b0;
          state_d       = S_REQ;
        end else if (id_ready) begin
          pc_advance    = 1'b1;
          instr_valid_d = 1'b0;
          state_d       = S_REQ;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      req_pc_q    <= '0;
      wait_cnt_q  <= '0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      fetch_err   <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_pc_q    <= req_pc_d;
      wait_cnt_q  <= wait_cnt_d;
      instr       <= instr_d;
      instr_pc    <= instr_pc_d;
      instr_valid <= instr_valid_d;
      fetch_err   <= fetch_err_d;
    end
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter TIMEOUT, default 15, SHALL set the maximum number of WAIT/DRAIN cycles before a fetch is abandoned.
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL change on its rising edge only.
REQ-003 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 pc  input  32  SHALL carry the current program counter from the PC register.
REQ-005 flush  input  1  SHALL indicate a taken jump or branch; any in-flight or held instruction is discarded.
REQ-006 id_ready  input  1  SHALL indicate that decode accepts the held instruction this cycle.
REQ-007 imem_req  output  1  SHALL request an instruction-memory read.
REQ-008 imem_addr  output  32  SHALL carry the read address: {pc[31:2],2'b00}.
REQ-009 imem_gnt  input  1  SHALL indicate that memory accepted the request this cycle.
REQ-010 imem_rvalid  input  1  SHALL indicate that imem_rdata is valid this cycle.
REQ-011 imem_rdata  input  32  SHALL carry the returned instruction word.
REQ-012 instr, instr_pc  output  32 each  SHALL carry the held instruction and its word-aligned address.
REQ-013 instr_valid  output  1  SHALL flag that instr/instr_pc are valid.
REQ-014 pc_advance  output  1  SHALL pulse for one cycle when decode accepts an instruction, enabling the PC update.
REQ-015 fetch_err  output  1  SHALL be a sticky timeout flag.

Function
REQ-016 States SHALL be IDLE, REQ, WAIT, FULL, and DRAIN; imem_req SHALL be 1 only in REQ.
REQ-017 IDLE SHALL go to REQ unconditionally on the first clock after reset deassertion.
REQ-018 REQ with imem_gnt=1 and flush=0 SHALL go to WAIT and latch req_pc={pc[31:2],2'b00}.
REQ-019 REQ with imem_gnt=0 SHALL stay in REQ, with imem_addr tracking pc combinationally; flush has no effect in this case.
REQ-020 REQ with imem_gnt=1 and flush=1 SHALL go to DRAIN, because the granted read targets a stale address.
REQ-021 WAIT with imem_rvalid=1 and flush=0 SHALL go to FULL and load instr=imem_rdata, instr_pc=req_pc, and instr_valid=1 on the same edge.
REQ-022 WAIT with flush=1 SHALL discard the fetch: if imem_rvalid=1 in the same cycle, go to REQ with the data dropped; otherwise go to DRAIN.
REQ-023 DRAIN SHALL drop the first imem_rvalid beat and then go to REQ; instr_valid SHALL stay 0 throughout.
REQ-024 FULL SHALL hold instr, instr_pc, and instr_valid=1 stable until the hand-off or a flush.
REQ-025 FULL with id_ready=1 and flush=0 SHALL assert pc_advance combinationally in that cycle, clear instr_valid on the edge, and go to REQ.
REQ-026 FULL with flush=1 SHALL clear instr_valid on the edge and go to REQ with pc_advance=0; flush SHALL win over a simultaneous id_ready.
REQ-027 pc_advance SHALL be 0 in every state other than FULL.
REQ-028 A wait counter SHALL clear on entry to WAIT or DRAIN and increment on each cycle spent there without imem_rvalid.
REQ-029 When the wait counter reaches TIMEOUT, the block SHALL set fetch_err=1 and return to REQ, which reissues the current pc.
REQ-030 fetch_err SHALL clear only on reset.
REQ-031 The wait counter width SHALL be $clog2(TIMEOUT+1) and it SHALL not wrap.
REQ-032 At most one read SHALL be outstanding; imem_rvalid in IDLE, REQ, or FULL SHALL be ignored.

Reset
REQ-033 While reset=1, the block SHALL hold state=IDLE, imem_req=0, instr=0, instr_pc=0, instr_valid=0, pc_advance=0, fetch_err=0, and wait counter=0, regardless of clk.
REQ-034 Reset asserted mid-fetch SHALL abandon the outstanding read, and the first imem_rvalid after reset SHALL be ignored.

Verification
REQ-035 The bench SHALL cover the basic fetch: pc=0x00400000, gnt the same cycle, rvalid 2 cycles later with rdata=0x8C220004, id_ready=1 -> instr_valid=1 with instr_pc=0x00400000, and a single pc_advance pulse.
REQ-036 The bench SHALL cover backpressure: id_ready=0 for 5 cycles -> instr and instr_valid stable, pc_advance=0, imem_req=0 throughout.
REQ-037 The bench SHALL cover flush during WAIT: flush=1 one cycle after gnt, rvalid 3 cycles later with rdata=0xDEADBEEF -> instr_valid never rises, and the next imem_req carries the new pc=0x00400040.
REQ-038 The bench SHALL cover simultaneous events: in FULL, flush=1 and id_ready=1 -> pc_advance=0 and instr_valid=0 next cycle; separately, in WAIT, flush=1 and rvalid=1 together -> next state REQ with data dropped.
REQ-039 The bench SHALL cover timeout: with TIMEOUT=15, no rvalid for 15 cycles after gnt -> fetch_err=1 (sticky) and imem_req reasserted with the same pc.
REQ-040 The bench SHALL cover mid-fetch reset: reset pulsed during WAIT -> all outputs 0 immediately, and a stray rvalid afterwards does not set instr_valid.
